// File: rtl/seq_detector.sv
// Parametrised Moore sequence detector with overlap-exact matching.
// Optional match counter enabled by SEQ_DETECTOR_COUNT_EN.
module seq_detector #(
  parameter int                   SYM_W   = 2,
  parameter int                   LEN     = 3,
  parameter logic [SYM_W*LEN-1:0] PATTERN = {2'd1, 2'd2, 2'd3},
  parameter bit                   HOLD    = 1'b1,
  parameter logic [SYM_W-1:0]     CLR_SYM = '0,
  parameter int                   CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [SYM_W-1:0]           num,
  output logic                       ans,
  output logic [$clog2(LEN+1)-1:0]   prog,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int PW = $clog2(LEN + 1);
  localparam int HL = (LEN > 1) ? LEN - 1 : 1;

  typedef enum logic {SEARCH, MATCH} state_t;

  function automatic logic [SYM_W-1:0] psym(input int i);
    return PATTERN[SYM_W*(LEN-1-i) +: SYM_W];
  endfunction

  // longest proper suffix of PATTERN that is also a prefix
  function automatic int fail_len();
    int f;
    bit ok;
    f = 0;
    for (int l = 1; l < LEN; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++)
        if (psym(i) != psym(LEN - l + i)) ok = 1'b0;
      if (ok) f = l;
    end
    return f;
  endfunction

  localparam int F = fail_len();

  state_t            state_q, state_d;
  logic [PW-1:0]     prog_q, prog_d;
  logic [SYM_W-1:0]  hist_q [HL];
  logic [SYM_W-1:0]  hist_d [HL];
  logic [SYM_W-1:0]  hist_sh [HL];
  int                base, best;
  logic              hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      prog_q  <= '0;
      hist_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      hist_q  <= hist_d;
    end
  end

  // hist_q[0] is the most recent accepted symbol
  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    hist_d  = hist_q;
    hist_sh = hist_q;
    base    = int'(prog_q);
    best    = 0;
    hit     = 1'b0;
    if (state_q == MATCH && !HOLD) base = F;
    hist_sh[0] = num;
    for (int j = 1; j < HL; j++) hist_sh[j] = hist_q[j-1];
    for (int k = 1; k <= LEN; k++) begin
      hit = (num == psym(k-1)) && (k <= base + 1);
      for (int i = 0; i < LEN - 1; i++)
        if (i < k - 1) hit = hit && (hist_q[k-2-i] == psym(i));
      if (hit) best = k;
    end
    unique case (state_q)
      SEARCH: begin
        if (in_valid) begin
          hist_d = hist_sh;
          prog_d = PW'(best);
          if (best == LEN) state_d = MATCH;
        end
      end
      MATCH: begin
        if (HOLD) begin
          if (in_valid && num == CLR_SYM) begin
            state_d = SEARCH;
            prog_d  = '0;
            hist_d  = '{default: '0};
          end
        end else if (in_valid) begin
          hist_d  = hist_sh;
          prog_d  = PW'(best);
          state_d = (best == LEN) ? MATCH : SEARCH;
        end else begin
          prog_d  = PW'(F);
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    ans  = (state_q == MATCH);
    prog = prog_q;
  end

`ifdef SEQ_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             bump;

  assign bump = (state_d == MATCH) && (state_q == SEARCH || !HOLD);

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (bump && cnt_q != '1)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: HOLD=1 defaults, 1-bit overlap
// pattern with HOLD=0, and counter saturation at CNT_W=2.
module tb_seq_detector;

  logic       clk;
  logic       reset;
  logic       v0, v1, v2;
  logic [1:0] n0, n2;
  logic       n1;
  logic       a0, a1, a2;
  logic [1:0] p0, p1, p2;
  logic [7:0] c0;
  logic [7:0] c1;
  logic [1:0] c2;

  int errs = 0;
  int checks = 0;

  seq_detector #(.HOLD(1'b1)) d0 (
    .clk(clk), .reset(reset), .in_valid(v0), .num(n0),
    .ans(a0), .prog(p0), .match_cnt(c0)
  );

  seq_detector #(
    .SYM_W(1), .LEN(3), .PATTERN(3'b101), .HOLD(1'b0), .CLR_SYM(1'b0)
  ) d1 (
    .clk(clk), .reset(reset), .in_valid(v1), .num(n1),
    .ans(a1), .prog(p1), .match_cnt(c1)
  );

  seq_detector #(.HOLD(1'b0), .CNT_W(2)) d2 (
    .clk(clk), .reset(reset), .in_valid(v2), .num(n2),
    .ans(a2), .prog(p2), .match_cnt(c2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] n;
    logic       a;
    int         p;
    int         c;
  } vec_t;

  vec_t tbl [23];

  function automatic int ec(input int x);
`ifdef SEQ_DETECTOR_COUNT_EN
    return x;
`else
    return 0 * x;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0; reset = 1;
    v0 = 0; v1 = 0; v2 = 0;
    n0 = 0; n1 = 0; n2 = 0;

    tbl[0]  = '{1'b1, 2'd1, 1'b0, 1, 0};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 2, 0};
    tbl[2]  = '{1'b0, 2'd3, 1'b0, 2, 0};
    tbl[3]  = '{1'b1, 2'd3, 1'b1, 3, 1};
    tbl[4]  = '{1'b1, 2'd1, 1'b1, 3, 1};
    tbl[5]  = '{1'b1, 2'd2, 1'b1, 3, 1};
    tbl[6]  = '{1'b1, 2'd3, 1'b1, 3, 1};
    tbl[7]  = '{1'b1, 2'd2, 1'b1, 3, 1};
    tbl[8]  = '{1'b1, 2'd0, 1'b0, 0, 1};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 1, 1};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 1, 1};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 2, 1};
    tbl[12] = '{1'b1, 2'd1, 1'b0, 1, 1};
    tbl[13] = '{1'b0, 2'd0, 1'b0, 1, 1};
    tbl[14] = '{1'b1, 2'd2, 1'b0, 2, 1};
    tbl[15] = '{1'b1, 2'd3, 1'b1, 3, 2};
    tbl[16] = '{1'b1, 2'd0, 1'b0, 0, 2};
    tbl[17] = '{1'b1, 2'd3, 1'b0, 0, 2};
    tbl[18] = '{1'b1, 2'd2, 1'b0, 0, 2};
    tbl[19] = '{1'b1, 2'd1, 1'b0, 1, 2};
    tbl[20] = '{1'b0, 2'd0, 1'b0, 1, 2};
    tbl[21] = '{1'b1, 2'd2, 1'b0, 2, 2};
    tbl[22] = '{1'b1, 2'd0, 1'b0, 0, 2};

    tick();
    tick();
    reset = 0;
    chk("rst_ans0", int'(a0), 0);
    chk("rst_prog0", int'(p0), 0);
    chk("rst_cnt0", int'(c0), 0);
    chk("rst_ans1", int'(a1), 0);
    chk("rst_prog2", int'(p2), 0);

    for (int i = 0; i < 23; i++) begin
      v0 = tbl[i].v;
      n0 = tbl[i].n;
      tick();
      chk($sformatf("vec%0d_ans", i), int'(a0), int'(tbl[i].a));
      chk($sformatf("vec%0d_prog", i), int'(p0), tbl[i].p);
      chk($sformatf("vec%0d_cnt", i), int'(c0), ec(tbl[i].c));
    end

    // partial 1,2 then reset with a valid 3 present on the same edge
    v0 = 1; n0 = 1; tick();
    n0 = 2; tick();
    chk("pre_rst_prog", int'(p0), 2);
    reset = 1; n0 = 3; tick();
    reset = 0;
    chk("mid_rst_prog", int'(p0), 0);
    chk("mid_rst_ans", int'(a0), 0);
    chk("mid_rst_cnt", int'(c0), 0);
    n0 = 3; tick();
    chk("post_rst_ans", int'(a0), 0);
    chk("post_rst_prog", int'(p0), 0);
    v0 = 0;

    // 1-bit pattern 101, pulse mode with overlap
    begin
      logic sym [5];
      int   ep [5];
      int   ea [5];
      int   ecn [5];
      sym = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      ep  = '{1, 2, 3, 2, 3};
      ea  = '{0, 0, 1, 0, 1};
      ecn = '{0, 0, 1, 1, 2};
      for (int i = 0; i < 5; i++) begin
        v1 = 1; n1 = sym[i];
        tick();
        chk($sformatf("b101_%0d_ans", i), int'(a1), ea[i]);
        chk($sformatf("b101_%0d_prog", i), int'(p1), ep[i]);
        chk($sformatf("b101_%0d_cnt", i), int'(c1), ec(ecn[i]));
      end
      v1 = 0;
      tick();
      chk("b101_idle_ans", int'(a1), 0);
      chk("b101_idle_prog", int'(p1), 1);
      chk("b101_idle_cnt", int'(c1), ec(2));
      tick();
      chk("b101_idle2_prog", int'(p1), 1);
    end

    // five back-to-back matches on a 2-bit counter
    for (int i = 0; i < 15; i++) begin
      int m;
      v2 = 1;
      n2 = 2'(i % 3 + 1);
      tick();
      m = (i + 1) / 3;
      if (m > 3) m = 3;
      chk($sformatf("sat_%0d_ans", i), int'(a2), (i % 3 == 2) ? 1 : 0);
      chk($sformatf("sat_%0d_prog", i), int'(p2), i % 3 + 1);
      chk($sformatf("sat_%0d_cnt", i), int'(c2), ec(m));
    end
    v2 = 0;
    tick();
    chk("sat_end_ans", int'(a2), 0);
    chk("sat_end_prog", int'(p2), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
